channel_state_ram: RTL and testbench

Parametrised, multi-channel tracking-state memory that holds the per-channel loop state (accumulators, NCO phases, discriminator history) for every tracking channel. It supersedes the fixed dual-port wrapper: two independent ports addressed by {channel, word}, 2-cycle registered reads with a read-valid strobe, a hardware clear sequencer for one channel or all channels, and defined collision behaviour. Port A serves the tracking-loop datapath; port B serves the host/microprocessor interface.

---
 rtl/tracking_pkg.sv | 22 ++
 rtl/dp_ram_core.sv | 30 +++
 rtl/channel_state_ram.sv | 170 +++++++++++++++++
 tb/tb_channel_state_ram.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tracking_pkg.sv
// Shared types and default sizing for the multi-channel tracking-state memory.
package tracking_pkg;

    localparam int DEF_NUM_CHANNELS      = 8;
    localparam int DEF_WORDS_PER_CHANNEL = 8;
    localparam int DEF_DATA_WIDTH        = 36;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < value) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Inferred true dual-port array: 1-cycle synchronous read, write-first on the
// same port, old data on a read from one port to an address the other writes.
module dp_ram_core #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clock,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic [DATA_WIDTH-1:0] a_q_o,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic [DATA_WIDTH-1:0] b_q_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Port A is written last so it wins should both enables ever coincide.
    always_ff @(posedge clock) begin
        if (b_we_i) mem_q[b_addr_i] <= b_data_i;
        if (a_we_i) mem_q[a_addr_i] <= a_data_i;
        a_q_o <= a_we_i ? a_data_i : mem_q[a_addr_i];
        b_q_o <= b_we_i ? b_data_i : mem_q[b_addr_i];
    end

endmodule

// File: rtl/channel_state_ram.sv
// Per-channel tracking-loop state memory: two ports, 2-cycle reads, clear sequencer.
// Define TRACKING_RAM_FORWARD_EN to forward cross-port same-cycle writes to reads.
module channel_state_ram
    import tracking_pkg::*;
#(
    parameter  int NUM_CHANNELS      = DEF_NUM_CHANNELS,
    parameter  int WORDS_PER_CHANNEL = DEF_WORDS_PER_CHANNEL,
    parameter  int DATA_WIDTH        = DEF_DATA_WIDTH,
    localparam int CHAN_WIDTH        = clog2(NUM_CHANNELS),
    localparam int WORD_WIDTH        = clog2(WORDS_PER_CHANNEL)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  clear_all,
    input  logic [CHAN_WIDTH-1:0] clear_chan,
    output logic                  busy,
    input  logic [CHAN_WIDTH-1:0] a_chan,
    input  logic [WORD_WIDTH-1:0] a_word,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_wren,
    input  logic                  a_rden,
    output logic [DATA_WIDTH-1:0] a_q,
    output logic                  a_valid,
    input  logic [CHAN_WIDTH-1:0] b_chan,
    input  logic [WORD_WIDTH-1:0] b_word,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_wren,
    input  logic                  b_rden,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic                  b_valid,
    output logic                  b_conflict
);

    localparam int ADDR_WIDTH = CHAN_WIDTH + WORD_WIDTH;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  all_q, all_d;
    logic [CHAN_WIDTH-1:0] base_q, base_d;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] clr_addr;

    assign last_word = all_q ? (&cnt_q) : (&cnt_q[WORD_WIDTH-1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLR_CLEAR;
            cnt_q   <= '0;
            all_q   <= 1'b1;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            all_q   <= all_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        all_d   = all_q;
        base_d  = base_q;
        case (state_q)
            CLR_IDLE: begin
                if (clear_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                    all_d   = clear_all;
                    base_d  = clear_chan;
                end
            end
            CLR_CLEAR: begin
                cnt_d = last_word ? '0 : cnt_q + 1'b1;
                if (last_word) state_d = CLR_IDLE;
            end
        endcase
    end

    // In single-channel mode only the word bits of the counter advance.
    always_comb begin
        busy     = (state_q == CLR_CLEAR);
        clr_addr = all_q ? cnt_q : {base_q, cnt_q[WORD_WIDTH-1:0]};
    end

    logic [ADDR_WIDTH-1:0] a_addr, b_addr, ram_a_addr;
    logic [DATA_WIDTH-1:0] ram_a_data, ram_a_q, ram_b_q;
    logic                  a_re, a_we, b_re, b_we, b_we_eff, conflict, ram_a_we;

    assign a_addr   = {a_chan, a_word};
    assign b_addr   = {b_chan, b_word};
    assign a_re     = a_rden & ~busy;
    assign a_we     = a_wren & ~busy;
    assign b_re     = b_rden & ~busy;
    assign b_we     = b_wren & ~busy;
    assign conflict = a_we & b_we & (a_addr == b_addr);
    assign b_we_eff = b_we & ~conflict;

    // The clear sequencer borrows port A; host requests are dropped meanwhile.
    assign ram_a_we   = busy | a_we;
    assign ram_a_addr = busy ? clr_addr : a_addr;
    assign ram_a_data = busy ? '0 : a_data;

    dp_ram_core #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .clock   (clock),
        .a_we_i  (ram_a_we),
        .a_addr_i(ram_a_addr),
        .a_data_i(ram_a_data),
        .a_q_o   (ram_a_q),
        .b_we_i  (b_we_eff),
        .b_addr_i(b_addr),
        .b_data_i(b_data),
        .b_q_o   (ram_b_q)
    );

    logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;

`ifdef TRACKING_RAM_FORWARD_EN
    logic                  a_fwd_q, b_fwd_q;
    logic [DATA_WIDTH-1:0] a_fwd_data_q, b_fwd_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_fwd_q      <= 1'b0;
            b_fwd_q      <= 1'b0;
            a_fwd_data_q <= '0;
            b_fwd_data_q <= '0;
        end else begin
            a_fwd_q      <= a_re & b_we_eff & (a_addr == b_addr);
            b_fwd_q      <= b_re & a_we & (a_addr == b_addr);
            a_fwd_data_q <= b_data;
            b_fwd_data_q <= a_data;
        end
    end

    assign a_rd_data = a_fwd_q ? a_fwd_data_q : ram_a_q;
    assign b_rd_data = b_fwd_q ? b_fwd_data_q : ram_b_q;
`else
    assign a_rd_data = ram_a_q;
    assign b_rd_data = ram_b_q;
`endif

    logic [1:0] a_vld_q, b_vld_q;
    logic       conflict_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_vld_q    <= '0;
            b_vld_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            conflict_q <= 1'b0;
        end else begin
            a_vld_q    <= {a_vld_q[0], a_re};
            b_vld_q    <= {b_vld_q[0], b_re};
            conflict_q <= conflict;
            if (a_vld_q[0]) a_q <= a_rd_data;
            if (b_vld_q[0]) b_q <= b_rd_data;
        end
    end

    assign a_valid    = a_vld_q[1];
    assign b_valid    = b_vld_q[1];
    assign b_conflict = conflict_q;

endmodule

// File: tb/tb_channel_state_ram.sv
// Directed self-checking bench for channel_state_ram with default parameters.
module tb_channel_state_ram;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear_req = 1'b0, clear_all = 1'b0;
    logic [2:0]  clear_chan = '0;
    logic        busy;
    logic [2:0]  a_chan = '0, b_chan = '0;
    logic [2:0]  a_word = '0, b_word = '0;
    logic [35:0] a_data = '0, b_data = '0;
    logic        a_wren = 1'b0, a_rden = 1'b0, b_wren = 1'b0, b_rden = 1'b0;
    logic [35:0] a_q, b_q;
    logic        a_valid, b_valid, b_conflict;

    int checks = 0;
    int errors = 0;

    channel_state_ram dut (
        .clock(clock), .reset(reset),
        .clear_req(clear_req), .clear_all(clear_all), .clear_chan(clear_chan),
        .busy(busy),
        .a_chan(a_chan), .a_word(a_word), .a_data(a_data),
        .a_wren(a_wren), .a_rden(a_rden), .a_q(a_q), .a_valid(a_valid),
        .b_chan(b_chan), .b_word(b_word), .b_data(b_data),
        .b_wren(b_wren), .b_rden(b_rden), .b_q(b_q), .b_valid(b_valid),
        .b_conflict(b_conflict)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] pat(input int addr);
        return 36'hA00000000 | 36'(addr);
    endfunction

    task automatic wr_a(input logic [2:0] ch, input logic [2:0] w, input logic [35:0] d);
        a_chan = ch; a_word = w; a_data = d; a_wren = 1'b1;
        tick();
        a_wren = 1'b0;
    endtask

    task automatic rd(input bit on_b, input logic [2:0] ch, input logic [2:0] w,
                      output logic [35:0] d);
        if (on_b) begin b_chan = ch; b_word = w; b_rden = 1'b1; end
        else      begin a_chan = ch; a_word = w; a_rden = 1'b1; end
        tick();
        a_rden = 1'b0; b_rden = 1'b0;
        chk("rd_valid_early", 64'(on_b ? b_valid : a_valid), 64'(0));
        tick();
        chk("rd_valid", 64'(on_b ? b_valid : a_valid), 64'(1));
        d = on_b ? b_q : a_q;
    endtask

    task automatic count_busy(input string tag, input int start, input int exp);
        int n;
        n = start;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] d;
        logic [35:0] exp;

        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_a_q", 64'(a_q), 64'(0));
        chk("rst_b_q", 64'(b_q), 64'(0));
        chk("rst_a_valid", 64'(a_valid), 64'(0));
        chk("rst_b_valid", 64'(b_valid), 64'(0));
        chk("rst_conflict", 64'(b_conflict), 64'(0));
        reset = 1'b0;
        count_busy("init_busy_cycles", 0, 64);

        for (int i = 0; i < 64; i++) begin
            rd(1'b0, 3'(i >> 3), 3'(i), d);
            chk("init_zero", 64'(d), 64'(0));
        end

        // A write at N, B read at N+1, valid at N+3
        a_chan = 3'd3; a_word = 3'd5; a_data = 36'h123456789; a_wren = 1'b1;
        tick();
        a_wren = 1'b0;
        b_chan = 3'd3; b_word = 3'd5; b_rden = 1'b1;
        tick();
        b_rden = 1'b0;
        chk("xport_valid_n2", 64'(b_valid), 64'(0));
        tick();
        chk("xport_valid_n3", 64'(b_valid), 64'(1));
        chk("xport_data", 64'(b_q), 64'h123456789);

        // same-address dual write: A wins, conflict pulses once
        a_chan = 3'd1; a_word = 3'd0; a_data = 36'hAAA; a_wren = 1'b1;
        b_chan = 3'd1; b_word = 3'd0; b_data = 36'hBBB; b_wren = 1'b1;
        tick();
        a_wren = 1'b0; b_wren = 1'b0;
        chk("conflict_pulse", 64'(b_conflict), 64'(1));
        tick();
        chk("conflict_clear", 64'(b_conflict), 64'(0));
        rd(1'b1, 3'd1, 3'd0, d);
        chk("conflict_data", 64'(d), 64'hAAA);

        // mixed-port read during write
        wr_a(3'd2, 3'd2, 36'h9);
        a_chan = 3'd2; a_word = 3'd2; a_data = 36'h5; a_wren = 1'b1;
        b_chan = 3'd2; b_word = 3'd2; b_rden = 1'b1;
        tick();
        a_wren = 1'b0; b_rden = 1'b0;
        tick();
`ifdef TRACKING_RAM_FORWARD_EN
        exp = 36'h5;
`else
        exp = 36'h9;
`endif
        chk("mixed_valid", 64'(b_valid), 64'(1));
        chk("mixed_data", 64'(b_q), 64'(exp));
        rd(1'b1, 3'd2, 3'd2, d);
        chk("mixed_after", 64'(d), 64'h5);

        // same-port read and write: new data returned
        a_chan = 3'd0; a_word = 3'd1; a_data = 36'h77; a_wren = 1'b1; a_rden = 1'b1;
        tick();
        a_wren = 1'b0; a_rden = 1'b0;
        tick();
        chk("sameport_valid", 64'(a_valid), 64'(1));
        chk("sameport_data", 64'(a_q), 64'h77);

        // fill, then clear channel 4 only
        for (int i = 0; i < 64; i++) wr_a(3'(i >> 3), 3'(i), pat(i));
        clear_req = 1'b1; clear_all = 1'b0; clear_chan = 3'd4;
        tick();
        clear_req = 1'b0;
        chk("clr_busy_start", 64'(busy), 64'(1));
        a_chan = 3'd0; a_word = 3'd0; a_data = 36'hDEAD; a_wren = 1'b1;
        b_chan = 3'd5; b_word = 3'd0; b_rden = 1'b1;
        tick();
        a_wren = 1'b0; b_rden = 1'b0;
        clear_req = 1'b1; clear_all = 1'b1;
        tick();
        clear_req = 1'b0; clear_all = 1'b0;
        chk("busy_read_dropped", 64'(b_valid), 64'(0));
        count_busy("chan_clear_cycles", 2, 8);
        for (int i = 0; i < 64; i++) begin
            rd(1'b1, 3'(i >> 3), 3'(i), d);
            chk("after_chan_clear", 64'(d), 64'(((i >> 3) == 4) ? 36'h0 : pat(i)));
        end

        // reset during a channel clear with a read in flight
        rd(1'b0, 3'd1, 3'd1, d);
        chk("pre_reset_q", 64'(a_q), 64'(pat(9)));
        a_chan = 3'd1; a_word = 3'd1; a_rden = 1'b1;
        clear_req = 1'b1; clear_all = 1'b0; clear_chan = 3'd2;
        tick();
        a_rden = 1'b0; clear_req = 1'b0;
        chk("midclr_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        chk("midrst_a_valid", 64'(a_valid), 64'(0));
        chk("midrst_a_q", 64'(a_q), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(1));
        tick();
        chk("midrst_no_strobe", 64'(a_valid), 64'(0));
        reset = 1'b0;
        count_busy("midrst_busy_cycles", 0, 64);
        chk("midrst_valid_idle", 64'(a_valid), 64'(0));
        rd(1'b0, 3'd1, 3'd1, d);
        chk("midrst_cleared", 64'(d), 64'(0));
        rd(1'b1, 3'd7, 3'd7, d);
        chk("midrst_cleared_last", 64'(d), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
